// File: rtl/sonar_uc.sv
// rtl/sonar_uc.sv - sonar control unit: ping-pong servo sweep, measure, frame transmit
module sonar_uc #(
    parameter int N_POS   = 8,
    parameter int N_CHARS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       tick_2s,
    input  logic       sensor_pronto,
    input  logic       serial_pronto,
    output logic       medicao,
    output logic       transmissao,
    output logic       limpa_tick_2s,
    output logic       conta_tick_2s,
    output logic [2:0] sel_posicao,
    output logic [2:0] sel_rom,
    output logic [2:0] sel_transmissao,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        ESPERA_2S      = 4'd2,
        MEDE           = 4'd3,
        AGUARDA_MEDIDA = 4'd4,
        TRANSMITE      = 4'd5,
        AGUARDA_SERIAL = 4'd6,
        PROX_CHAR      = 4'd7,
        PROX_POSICAO   = 4'd8
    } state_t;

    localparam logic [2:0] LAST_POS  = 3'(N_POS - 1);
    localparam logic [2:0] LAST_CHAR = 3'(N_CHARS - 1);

    state_t     state;
    state_t     next_state;
    logic [2:0] pos;
    logic [2:0] char_idx;
    logic       dir_down;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= INICIAL;
            pos      <= 3'd0;
            dir_down <= 1'b0;
            char_idx <= 3'd0;
        end else begin
            state <= next_state;
            case (state)
                PREPARA: begin
                    pos      <= 3'd0;
                    dir_down <= 1'b0;
                    char_idx <= 3'd0;
                end
                PROX_CHAR: char_idx <= char_idx + 3'd1;
                PROX_POSICAO: begin
                    char_idx <= 3'd0;
                    // Stopping the sweep parks the servo back at the origin.
                    if (!ligar) begin
                        pos      <= 3'd0;
                        dir_down <= 1'b0;
                    end else if (!dir_down) begin
                        if (pos == LAST_POS) begin
                            pos      <= pos - 3'd1;
                            dir_down <= 1'b1;
                        end else begin
                            pos <= pos + 3'd1;
                        end
                    end else begin
                        if (pos == 3'd0) begin
                            pos      <= 3'd1;
                            dir_down <= 1'b0;
                        end else begin
                            pos <= pos - 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state    = state;
        medicao       = 1'b0;
        transmissao   = 1'b0;
        limpa_tick_2s = 1'b0;
        conta_tick_2s = 1'b0;
        pronto        = 1'b0;
        case (state)
            INICIAL:        if (ligar) next_state = PREPARA;
            PREPARA: begin
                limpa_tick_2s = 1'b1;
                next_state    = ESPERA_2S;
            end
            ESPERA_2S: begin
                conta_tick_2s = 1'b1;
                if (tick_2s) next_state = MEDE;
            end
            MEDE: begin
                medicao    = 1'b1;
                next_state = AGUARDA_MEDIDA;
            end
            AGUARDA_MEDIDA: if (sensor_pronto) next_state = TRANSMITE;
            TRANSMITE: begin
                transmissao = 1'b1;
                next_state  = AGUARDA_SERIAL;
            end
            AGUARDA_SERIAL: begin
                if (serial_pronto)
                    next_state = (char_idx == LAST_CHAR) ? PROX_POSICAO : PROX_CHAR;
            end
            PROX_CHAR:      next_state = TRANSMITE;
            PROX_POSICAO: begin
                pronto        = 1'b1;
                limpa_tick_2s = 1'b1;
                next_state    = ligar ? ESPERA_2S : INICIAL;
            end
            default:        next_state = INICIAL;
        endcase
    end

    assign sel_posicao     = pos;
    assign sel_rom         = pos;
    assign sel_transmissao = char_idx;
    assign db_estado       = state;

endmodule

// File: tb/tb_sonar_uc.sv
// tb/tb_sonar_uc.sv - randomized bench for sonar_uc against a frame-level reference model
module tb_sonar_uc;

    localparam int NP = 8;
    localparam int NC = 8;

    logic       clock = 1'b0;
    logic       reset, ligar, tick_2s, sensor_pronto, serial_pronto;
    logic       medicao, transmissao, limpa_tick_2s, conta_tick_2s, pronto;
    logic [2:0] sel_posicao, sel_rom, sel_transmissao;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int started = 0;
    int pronto_seen = 0;
    int max_pos_seen = 0;

    // Model: protocol phase (numbered by the debug code), count of positions
    // visited since sweep start, and character index within the frame.
    int m_phase = 0;
    int m_k = 0;
    int m_ch = 0;

    sonar_uc #(.N_POS(NP), .N_CHARS(NC)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .tick_2s(tick_2s),
        .sensor_pronto(sensor_pronto), .serial_pronto(serial_pronto),
        .medicao(medicao), .transmissao(transmissao), .limpa_tick_2s(limpa_tick_2s),
        .conta_tick_2s(conta_tick_2s), .sel_posicao(sel_posicao), .sel_rom(sel_rom),
        .sel_transmissao(sel_transmissao), .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Servo position for the k-th visit of a ping-pong sweep, period 2*NP-2.
    function automatic int pingpong(input int k);
        int m;
        m = k % (2 * NP - 2);
        return (m < NP) ? m : (2 * NP - 2 - m);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            m_phase <= 0; m_k <= 0; m_ch <= 0;
        end else begin
            case (m_phase)
                0: if (ligar) m_phase <= 1;
                1: begin m_phase <= 2; m_k <= 0; m_ch <= 0; end
                2: if (tick_2s) m_phase <= 3;
                3: m_phase <= 4;
                4: if (sensor_pronto) m_phase <= 5;
                5: m_phase <= 6;
                6: if (serial_pronto) m_phase <= (m_ch == NC - 1) ? 8 : 7;
                7: begin m_ch <= m_ch + 1; m_phase <= 5; end
                8: begin
                    m_ch <= 0;
                    if (ligar) begin m_k <= m_k + 1; m_phase <= 2; end
                    else begin m_k <= 0; m_phase <= 0; end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (started != 0) begin
            chk("db_estado", int'(db_estado), m_phase);
            chk("medicao", int'(medicao), int'(m_phase == 3));
            chk("transmissao", int'(transmissao), int'(m_phase == 5));
            chk("limpa_tick_2s", int'(limpa_tick_2s), int'(m_phase == 1 || m_phase == 8));
            chk("conta_tick_2s", int'(conta_tick_2s), int'(m_phase == 2));
            chk("pronto", int'(pronto), int'(m_phase == 8));
            chk("sel_posicao", int'(sel_posicao), pingpong(m_k));
            chk("sel_rom", int'(sel_rom), int'(sel_posicao));
            chk("sel_transmissao", int'(sel_transmissao), m_ch);
            if (pronto) pronto_seen++;
            if (int'(sel_posicao) > max_pos_seen) max_pos_seen = int'(sel_posicao);
        end
    end

    initial begin
        reset = 1'b1; ligar = 1'b1;
        tick_2s = 1'b0; sensor_pronto = 1'b0; serial_pronto = 1'b0;

        chk("pp0", pingpong(0), 0);
        chk("pp7", pingpong(7), 7);
        chk("pp8", pingpong(8), 6);
        chk("pp14", pingpong(14), 0);
        chk("pp15", pingpong(15), 1);

        @(posedge clock);
        started = 1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        @(negedge clock);
        chk("start_prepara", int'(db_estado), 1);
        chk("start_limpa", int'(limpa_tick_2s), 1);
        @(negedge clock);
        chk("start_espera", int'(db_estado), 2);
        chk("start_conta", int'(conta_tick_2s), 1);
        tick_2s = 1'b1;
        @(negedge clock);
        tick_2s = 1'b0;
        chk("mede_pulse", int'(medicao), 1);
        @(negedge clock);
        chk("mede_once", int'(medicao), 0);
        chk("aguarda_medida", int'(db_estado), 4);
        repeat (49) @(negedge clock);
        sensor_pronto = 1'b1;
        @(negedge clock);
        sensor_pronto = 1'b0;
        chk("first_tx", int'(transmissao), 1);
        chk("first_char", int'(sel_transmissao), 0);

        // First frame answered promptly; the model tracks the characters.
        repeat (NC) begin
            @(negedge clock);
            serial_pronto = 1'b1;
            @(negedge clock);
            serial_pronto = 1'b0;
            repeat (2) @(negedge clock);
        end
        chk("frame0_pronto", pronto_seen, 1);

        // Random flags (also spurious ones outside their wait states),
        // occasional ligar drops and reset pulses.
        repeat (8000) begin
            @(negedge clock);
            tick_2s       = ($urandom % 4) == 0;
            sensor_pronto = ($urandom % 3) == 0;
            serial_pronto = ($urandom % 2) == 0;
            reset         = ($urandom % 900) == 0;
            if (($urandom % 400) == 0) ligar = ~ligar;
            if (!ligar && ($urandom % 40) == 0) ligar = 1'b1;
        end
        reset = 1'b0;
        @(negedge clock);

        chk("progress_pronto", int'(pronto_seen > 16), 1);
        chk("reached_end_pos", max_pos_seen, NP - 1);

        // Reset while waiting for serial: everything clears by the next sample.
        ligar = 1'b1;
        tick_2s = 1'b1; sensor_pronto = 1'b1; serial_pronto = 1'b0;
        for (int i = 0; i < 200 && db_estado != 4'd6; i++) @(negedge clock);
        chk("reach_aguarda_serial", int'(db_estado), 6);
        reset = 1'b1;
        @(negedge clock);
        chk("reset_state", int'(db_estado), 0);
        chk("reset_outs", int'({medicao, transmissao, limpa_tick_2s, conta_tick_2s, pronto}), 0);
        chk("reset_sel", int'({sel_posicao, sel_transmissao}), 0);
        reset = 1'b0; tick_2s = 1'b0; sensor_pronto = 1'b0;
        repeat (3) @(negedge clock);

        started = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
